// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_parser_pkg: shared types and constants for the frame parser
package uart_frame_parser_pkg;
    typedef logic [7:0] u8;
    typedef logic [15:0] u16;
    localparam u8 DEFAULT_SYNC = 8'hA5;
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} frame_state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_BAD_LEN, ERR_BAD_CSUM, ERR_TIMEOUT} err_code_e;
endpackage

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops receiver FIFO bytes and sequences SYNC/LEN/payload/CSUM frames
// into a valid/ready payload stream with a per-frame ok/err verdict.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter u8  SYNC_BYTE      = DEFAULT_SYNC,
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       rx_empty,
    input  logic [7:0] rx_dout,
    output logic       rx_rd_en,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    frame_state_e    state_q, state_d;
    err_code_e       code_q, code_d;
    logic            pend_q, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic            ok_q, ok_d, err_q, err_d;
    u8               m_data_q, m_data_d, csum_q, csum_d, rem_q, rem_d;
    logic [TO_W-1:0] to_q, to_d;

    // A pop waits for the output register to drain, so a verdict can never overtake the last beat.
    assign rx_rd_en  = !srst && !rx_empty && !pend_q && !m_valid_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        m_last_d  = m_last_q && m_valid_d;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        csum_d    = csum_q;
        rem_d     = rem_q;
        to_d      = (state_q == HUNT) ? '0 : (m_valid_q && !m_ready) ? to_q : to_q + 1'b1;
        if (pend_q) begin
            to_d = '0;
            case (state_q)
                HUNT: if (rx_dout == SYNC_BYTE) state_d = LEN;
                LEN: begin
                    csum_d = rx_dout;
                    rem_d  = rx_dout;
                    if (rx_dout == 8'd0) begin
                        state_d = CSUM;
                    end else if (32'(rx_dout) > MAX_LEN) begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_LEN;
                        state_d = HUNT;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    m_data_d  = rx_dout;
                    m_valid_d = 1'b1;
                    m_last_d  = rem_q == 8'd1;
                    csum_d    = csum_q ^ rx_dout;
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = CSUM;
                end
                CSUM: begin
                    ok_d    = rx_dout == csum_q;
                    err_d   = rx_dout != csum_q;
                    state_d = HUNT;
                    if (rx_dout != csum_q) code_d = ERR_BAD_CSUM;
                end
                default: ;
            endcase
        end else if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
            err_d    = 1'b1;
            code_d   = ERR_TIMEOUT;
            state_d  = HUNT;
            m_last_d = 1'b0;
            to_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= HUNT;
            code_q    <= ERR_NONE;
            pend_q    <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            csum_q    <= '0;
            rem_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pend_q    <= rx_rd_en;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            csum_q    <= csum_d;
            rem_q     <= rem_d;
            to_q      <= to_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and random frames checked against a frame-level reference parser
module tb_uart_frame_parser;
    localparam int TO = 200;
    localparam int MAXL = 64;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       rx_empty = 1'b1;
    logic       m_ready = 1'b1;
    logic [7:0] rx_dout = 8'h00;
    logic       rx_rd_en, m_valid, m_last, frame_ok, frame_err;
    logic [7:0] m_data;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] fq[$];
    logic [8:0] got_b[$], exp_b[$];
    int got_v[$], exp_v[$];
    int exp_code = 0;
    bit rand_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    uart_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .srst(srst), .rx_empty(rx_empty), .rx_dout(rx_dout), .rx_rd_en(rx_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at negedge, then play the FIFO and consumer just after posedge.
    task automatic tick();
        bit rd;
        @(negedge clk);
        rd = rx_rd_en;
        if (prev_stall) chk("hold", {m_valid, m_last, m_data}, {1'b1, prev_beat});
        if (m_valid && m_ready) got_b.push_back({m_last, m_data});
        if (frame_ok || frame_err) begin
            chk("one_verdict", frame_ok & frame_err, 0);
            chk("verdict_gap", m_valid, 0);
            got_v.push_back(frame_ok ? 0 : int'(err_code));
        end
        prev_stall = m_valid && !m_ready && !srst;
        prev_beat = {m_last, m_data};
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) rx_dout = fq.pop_front();
        rx_empty = fq.size() == 0;
        if (rand_ready) m_ready = 1'($urandom_range(0, 3) != 0);
    endtask

    // Reference: scan a byte stream frame by frame and list the beats and verdicts it must produce.
    task automatic model(input logic [7:0] b[$]);
        int i, len;
        logic [7:0] x;
        i = 0;
        while (i + 1 < b.size()) begin
            if (b[i] != SYNC) begin
                i++;
                continue;
            end
            len = int'(b[i+1]);
            if (len > MAXL) begin
                exp_v.push_back(1);
                exp_code = 1;
                i += 2;
                continue;
            end
            if (i + 2 + len >= b.size()) break;
            x = b[i+1];
            for (int k = 0; k < len; k++) begin
                exp_b.push_back({k == len - 1, b[i+2+k]});
                x ^= b[i+2+k];
            end
            if (b[i+2+len] == x) exp_v.push_back(0);
            else begin
                exp_v.push_back(2);
                exp_code = 2;
            end
            i += len + 3;
        end
    endtask

    // mode bit0: queue into FIFO, bit1: feed reference model
    task automatic frame(input logic [127:0] v, input int n, input int mode);
        logic [7:0] b[$];
        for (int i = 0; i < n; i++) b.push_back(v[8*(n-1-i) +: 8]);
        if (mode[0]) begin
            foreach (b[i]) fq.push_back(b[i]);
            rx_empty = fq.size() == 0;
        end
        if (mode[1]) model(b);
    endtask

    task automatic rand_frame();
        logic [7:0] b[$];
        int kind, len;
        logic [7:0] x, y;
        kind = $urandom_range(0, 3);
        if (kind == 0) begin
            repeat ($urandom_range(1, 4)) begin
                y = 8'($urandom_range(0, 255));
                b.push_back(y == SYNC ? 8'h00 : y);
            end
        end else if (kind == 1) begin
            b.push_back(SYNC);
            b.push_back(8'($urandom_range(MAXL + 1, 255)));
        end else begin
            len = ($urandom_range(0, 4) == 0) ? MAXL : $urandom_range(0, MAXL);
            x = 8'(len);
            b.push_back(SYNC);
            b.push_back(8'(len));
            for (int k = 0; k < len; k++) begin
                y = 8'($urandom_range(0, 255));
                b.push_back(y);
                x ^= y;
            end
            b.push_back(kind == 2 ? x : x ^ 8'($urandom_range(1, 255)));
        end
        foreach (b[i]) fq.push_back(b[i]);
        rx_empty = 1'b0;
        model(b);
    endtask

    task automatic drain(input string tag);
        int idle, n;
        idle = 0;
        n = 0;
        while (idle < 12 && n < 20000) begin
            tick();
            n++;
            idle = (fq.size() == 0 && !m_valid && !rx_rd_en) ? idle + 1 : 0;
        end
        chk({tag, "_drain"}, n < 20000, 1);
        chk({tag, "_nbeats"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk({tag, "_beat"}, got_b[i], exp_b[i]);
        chk({tag, "_nverd"}, got_v.size(), exp_v.size());
        for (int i = 0; i < exp_v.size() && i < got_v.size(); i++) chk({tag, "_verd"}, got_v[i], exp_v[i]);
        chk({tag, "_code"}, err_code, exp_code);
        got_b.delete();
        exp_b.delete();
        got_v.delete();
        exp_v.delete();
    endtask

    initial begin
        int n;
        frame(48'hA50311223303, 6, 3);
        tick();
        tick();
        chk("rst_rd_en", rx_rd_en, 0);
        chk("rst_out", {m_valid, m_last, m_data, frame_ok, frame_err, err_code}, 0);
        srst = 1'b0;
        drain("basic");
        frame(48'h00FF5AA50000, 6, 3);
        drain("garbage_len0");
        frame(16'hA541, 2, 3);
        frame(32'hA5017E7F, 4, 3);
        drain("bad_len");
        frame(40'hA502AABB00, 5, 3);
        drain("bad_csum");

        frame(24'hA50401, 3, 1);
        repeat (40) tick();
        chk("to_early", got_v.size(), 0);
        repeat (TO + 20) tick();
        exp_b.push_back({1'b0, 8'h01});
        exp_v.push_back(3);
        exp_code = 3;
        drain("timeout");

        m_ready = 1'b0;
        frame(24'hA50401, 3, 1);
        repeat (3 * TO) tick();
        chk("stall_verd", got_v.size(), 0);
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, 8'h01);
        m_ready = 1'b1;
        frame(32'h02030400, 4, 1);
        frame(56'hA5040102030400, 7, 2);
        drain("stall");

        m_ready = 1'b0;
        frame(64'hA505010203040504, 8, 1);
        n = 0;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        chk("mid_reach", m_valid, 1);
        srst = 1'b1;
        fq.delete();
        rx_empty = 1'b1;
        tick();
        srst = 1'b0;
        chk("mid_rst_out", {m_valid, m_last, m_data, frame_ok, frame_err, err_code}, 0);
        exp_code = 0;
        m_ready = 1'b1;
        drain("mid_rst_quiet");
        frame(40'hA5021234_26, 5, 3);
        drain("after_rst");

        rand_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            repeat (5) rand_frame();
            drain("rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
